// File: rtl/bidir_piso_tx_if.sv
// rtl/bidir_piso_tx_if.sv - load handshake and serial output bundle for bidir_piso_tx
interface bidir_piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] din;
    logic             mode;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid,
        output din,
        output mode,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  load_valid,
        input  din,
        input  mode,
        output load_ready,
        output sout,
        output sout_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/bidir_piso_tx.sv
// rtl/bidir_piso_tx.sv - bidirectional-order PISO transmitter; optional even parity bit via BIDIR_PISO_TX_PARITY_EN
module bidir_piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    bidir_piso_tx_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef BIDIR_PISO_TX_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic             mode_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    bit_idx;
    logic             accept;
    logic             sout_c;
    logic             sout_valid_c;
    logic             busy_c;
    logic             done_c;
    logic             load_ready_c;

    assign accept  = (state_q == IDLE) && bus.load_valid;
    // LSB-first walks the counter upward through the word, MSB-first mirrors it
    assign bit_idx = mode_q ? cnt_q : (LAST - cnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= bus.din;
                mode_q <= bus.mode;
                cnt_q  <= '0;
            end else if ((state_q == SHIFT) && (cnt_q != LAST)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        load_ready_c = 1'b0;
        sout_c       = 1'b0;
        sout_valid_c = 1'b0;
        busy_c       = 1'b0;
        done_c       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready_c = 1'b1;
                if (bus.load_valid) state_d = SHIFT;
            end
            SHIFT: begin
                sout_c       = data_q[bit_idx];
                sout_valid_c = 1'b1;
                busy_c       = 1'b1;
                if (cnt_q == LAST) begin
`ifdef BIDIR_PISO_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
                    done_c  = 1'b1;
`endif
                end
            end
`ifdef BIDIR_PISO_TX_PARITY_EN
            PARITY: begin
                sout_c       = ^data_q;
                sout_valid_c = 1'b1;
                busy_c       = 1'b1;
                done_c       = 1'b1;
                state_d      = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.load_ready = load_ready_c;
    assign bus.sout       = sout_c;
    assign bus.sout_valid = sout_valid_c;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
endmodule

// File: tb/tb_bidir_piso_tx.sv
// tb/tb_bidir_piso_tx.sv - scoreboard bench for bidir_piso_tx with loopback receiver model
module tb_bidir_piso_tx;
    localparam int WIDTH = 4;
`ifdef BIDIR_PISO_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    typedef struct packed {
        logic bit_v;
        logic done_v;
        logic is_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    bidir_piso_tx_if #(.WIDTH(WIDTH)) bus ();

    bidir_piso_tx #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic             rx_mode;
    logic [WIDTH-1:0] rx_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] d, input logic m);
        exp_t e;
        for (int k = 0; k < WIDTH; k++) begin
            e.bit_v   = m ? d[k] : d[WIDTH-1-k];
            e.is_data = 1'b1;
            e.done_v  = (FRAME_LEN == WIDTH) && (k == WIDTH - 1);
            exp_q.push_back(e);
        end
`ifdef BIDIR_PISO_TX_PARITY_EN
        e.bit_v   = ^d;
        e.is_data = 1'b0;
        e.done_v  = 1'b1;
        exp_q.push_back(e);
`endif
    endtask

    // Advance one clock, sample 1ns later and score whatever the DUT shows.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        check("busy_eq_valid", bus.busy, bus.sout_valid);
        check("ready_eq_idle", bus.load_ready, !bus.sout_valid);
        if (bus.sout_valid) begin
            check("bit_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sout", bus.sout, e.bit_v);
                check("done", bus.done, e.done_v);
                if (e.is_data)
                    rx_q = rx_mode ? {bus.sout, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], bus.sout};
            end
        end else begin
            check("idle_sout", bus.sout, 0);
            check("idle_done", bus.done, 0);
        end
    endtask

    task automatic begin_frame(input logic [WIDTH-1:0] d, input logic m, input logic keep);
        check("ready_before_load", bus.load_ready, 1);
        bus.load_valid = 1'b1;
        bus.din        = d;
        bus.mode       = m;
        rx_mode        = m;
        rx_q           = '0;
        push_frame(d, m);
        tick();
        check("first_bit_latency", bus.sout_valid, 1);
        if (!keep) begin
            bus.load_valid = 1'b0;
            bus.din        = ~d;
            bus.mode       = !m;
        end
    endtask

    task automatic rest_frame(input logic [WIDTH-1:0] d);
        for (int i = 1; i < FRAME_LEN; i++) begin
            tick();
            check("valid_in_frame", bus.sout_valid, 1);
        end
        check("done_on_last", bus.done, 1);
        check("queue_drained", exp_q.size(), 0);
        check("loopback_word", rx_q, d);
        tick();
        check("ready_after_done", bus.load_ready, 1);
        check("valid_after_done", bus.sout_valid, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        logic             rm;
        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.din        = '0;
        bus.mode       = 1'b0;
        rx_mode        = 1'b0;
        rx_q           = '0;
        tick();
        tick();
        check("rst_ready", bus.load_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.sout_valid, 0);
        rst = 1'b0;
        tick();

        begin_frame(4'b1011, 1'b1, 1'b0);
        rest_frame(4'b1011);
        begin_frame(4'b1011, 1'b0, 1'b0);
        rest_frame(4'b1011);

        begin_frame(4'b0110, 1'b1, 1'b0);
        rest_frame(4'b0110);
        begin_frame(4'b0110, 1'b0, 1'b0);
        rest_frame(4'b0110);

        // load_valid held high across a frame; the next word waits for IDLE
        begin_frame(4'b0001, 1'b1, 1'b1);
        bus.din = 4'b1111;
        rest_frame(4'b0001);
        begin_frame(4'b1111, 1'b1, 1'b0);
        rest_frame(4'b1111);

        // reset while the second bit is on the wire
        begin_frame(4'b1011, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sout", bus.sout, 0);
        check("abort_valid", bus.sout_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_ready", bus.load_ready, 1);
        check("abort_done", bus.done, 0);
        exp_q.delete();
        for (int i = 0; i < FRAME_LEN; i++) begin
            tick();
            check("no_done_after_abort", bus.done, 0);
        end

        for (int n = 0; n < 6; n++) begin
            rd = WIDTH'($urandom);
            rm = 1'($urandom_range(0, 1));
            begin_frame(rd, rm, 1'b0);
            rest_frame(rd);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
